// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller and datapath.
// This package holds the ALU codes, mux selects and instruction field positions.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    SRCB_B     = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } srcb_sel_e;

  typedef enum logic [1:0] {
    PCSRC_ALU     = 2'b00,
    PCSRC_ALUOUT  = 2'b01,
    PCSRC_JUMP    = 2'b10,
    PCSRC_ILLEGAL = 2'b11
  } pcsrc_sel_e;

  // Instruction field positions (LSB of each field, plus widths)
  localparam int OP_LSB    = 26;
  localparam int OP_BITS   = 6;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_BITS  = 16;
  localparam int JADDR_BITS = 26;

endpackage

// File: rtl/mc_regfile.sv
// Register file with two combinational read ports and one clocked write port.
// Register 0 is hard-wired to zero; reads during a write return the old contents.
module mc_regfile #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [REGBITS-1:0] ra1,
  input  logic [REGBITS-1:0] ra2,
  input  logic [REGBITS-1:0] wa,
  input  logic [WIDTH-1:0]   wd,
  output logic [WIDTH-1:0]   rd1,
  output logic [WIDTH-1:0]   rd2
);

  logic [WIDTH-1:0] mem [2**REGBITS];

  // No reset: register contents survive a datapath reset
  always_ff @(posedge clk) begin
    if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, the ALU and the register file.
// It is driven cycle by cycle by the controller's control word and returns op, funct and zero.
module mc_datapath
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               REGBITS  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lord,
  input  logic             irwrite,
  input  logic             regdst,
  input  logic             memtoreg,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic [1:0]       alusrcb,
  input  logic [2:0]       alucontrol,
  input  logic             pcen,
  input  logic [1:0]       pcsrc,
  input  logic [WIDTH-1:0] readdata,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             zero
);

  logic [WIDTH-1:0]   pc, ir, mdr, areg, breg, aluout;
  logic [WIDTH-1:0]   pcnext, srca, srcb, aluresult, diff;
  logic [WIDTH-1:0]   signimm, signimmsh, jumptarget;
  logic [WIDTH-1:0]   rd1, rd2, wd3;
  logic [REGBITS-1:0] wa3;

  assign op    = ir[OP_LSB +: OP_BITS];
  assign funct = ir[FUNCT_LSB +: 6];

  assign signimm    = {{(WIDTH-IMM_BITS){ir[IMM_BITS-1]}}, ir[IMM_BITS-1:0]};
  assign signimmsh  = {signimm[WIDTH-3:0], 2'b00};
  assign jumptarget = {pc[WIDTH-1 -: 4], ir[JADDR_BITS-1:0], 2'b00};

  assign wa3 = regdst   ? ir[RD_LSB +: REGBITS] : ir[RT_LSB +: REGBITS];
  assign wd3 = memtoreg ? mdr : aluout;

  mc_regfile #(
    .WIDTH   (WIDTH),
    .REGBITS (REGBITS)
  ) u_regfile (
    .clk (clk),
    .we  (regwrite),
    .ra1 (ir[RS_LSB +: REGBITS]),
    .ra2 (ir[RT_LSB +: REGBITS]),
    .wa  (wa3),
    .wd  (wd3),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  assign srca = alusrca ? areg : pc;

  always_comb begin
    srcb = breg;
    case (alusrcb)
      SRCB_B:     srcb = breg;
      SRCB_FOUR:  srcb = WIDTH'(4);
      SRCB_IMM:   srcb = signimm;
      SRCB_IMMSH: srcb = signimmsh;
      default:    srcb = breg;
    endcase
  end

  // slt takes the sign of the wrapped difference; codes 011/100/101 produce 0
  always_comb begin
    aluresult = '0;
    diff      = srca - srcb;
    case (alucontrol)
      ALU_AND: aluresult = srca & srcb;
      ALU_OR:  aluresult = srca | srcb;
      ALU_ADD: aluresult = srca + srcb;
      ALU_SUB: aluresult = diff;
      ALU_SLT: aluresult = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
      default: aluresult = '0;
    endcase
  end

  assign zero = (aluresult == '0);

  // The illegal select 11 falls back to the ALU result, like 00
  always_comb begin
    pcnext = aluresult;
    case (pcsrc)
      PCSRC_ALU:     pcnext = aluresult;
      PCSRC_ALUOUT:  pcnext = aluout;
      PCSRC_JUMP:    pcnext = jumptarget;
      PCSRC_ILLEGAL: pcnext = aluresult;
      default:       pcnext = aluresult;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      areg   <= '0;
      breg   <= '0;
      aluout <= '0;
    end else begin
      if (pcen)    pc <= pcnext;
      if (irwrite) ir <= readdata;
      mdr    <= readdata;
      areg   <= rd1;
      breg   <= rd2;
      aluout <= aluresult;
    end
  end

  assign adr       = lord ? aluout : pc;
  assign writedata = breg;

endmodule
